// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the SRAM.
// master = requester/memory side, slave = arbiter side.
interface dmem_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        freeze;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err0, err1, rdata0, rdata1, freeze,
    input  mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err0, err1, rdata0, rdata1, freeze,
    output mem_read, mem_write, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the single-ported data memory, with
// programmable SRAM wait states and a pipeline freeze for port 0.
module dmem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int unsigned DEPTH_BYTES   = 64
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [32:0] ADDR_LO  = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI  = ADDR_LO + 33'(DEPTH_BYTES) - 33'd4;
  localparam logic [3:0]  CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_last_grant;
  logic        r_port;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_any_req;
  logic        w_gnt_port;
  logic [31:0] w_gnt_addr;
  logic        w_in_range;
  logic        w_last_cycle;
  logic        w_ack0;
  logic        w_ack1;
  logic        w_unused;

  assign w_unused = ^{bus.addr0[1:0], bus.addr1[1:0]};

  // Range is judged on the address about to be latched, so the IDLE
  // decision can jump straight to DONE for an out-of-range access.
  always_comb begin
    w_any_req  = bus.req0 | bus.req1;
    w_gnt_port = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;
    w_gnt_addr = w_gnt_port ? {bus.addr1[31:2], 2'b00} : {bus.addr0[31:2], 2'b00};
    w_in_range = ({1'b0, w_gnt_addr} >= ADDR_LO) && ({1'b0, w_gnt_addr} <= ADDR_HI);
    w_last_cycle = (r_cnt == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = w_in_range ? ACCESS : DONE;
      ACCESS:  if (w_last_cycle) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_port       <= w_gnt_port;
            r_last_grant <= w_gnt_port;
            r_we         <= w_gnt_port ? bus.we1 : bus.we0;
            r_addr       <= w_gnt_addr;
            r_wdata      <= w_gnt_port ? bus.wdata1 : bus.wdata0;
            r_err        <= ~w_in_range;
            r_cnt        <= w_in_range ? CNT_INIT : '0;
            if (!w_in_range) begin
              if (w_gnt_port) r_rdata1 <= '0;
              else            r_rdata0 <= '0;
            end
          end
        end
        ACCESS: begin
          if (w_last_cycle) begin
            if (!r_we) begin
              if (r_port) r_rdata1 <= bus.mem_rdata;
              else        r_rdata0 <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ack0        = (r_state == DONE) && !r_port;
    w_ack1        = (r_state == DONE) &&  r_port;
    bus.ack0      = w_ack0;
    bus.ack1      = w_ack1;
    bus.err0      = w_ack0 & r_err;
    bus.err1      = w_ack1 & r_err;
    bus.rdata0    = r_rdata0;
    bus.rdata1    = r_rdata1;
    bus.freeze    = bus.req0 & ~w_ack0;
    bus.busy      = (r_state != IDLE);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    // Write strobe only in the last wait-state cycle: one write edge per access.
    if (r_state == ACCESS) begin
      bus.mem_read  = ~r_we;
      bus.mem_write = r_we & w_last_cycle;
      bus.mem_addr  = r_addr;
      bus.mem_wdata = r_wdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter at ACCESS_CYCLES of 2, 4 and 1, each
// instance backed by a 16-word memory at byte address 1024.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if b2 ();
  dmem_arbiter_if b4 ();
  dmem_arbiter_if b1 ();

  dmem_arbiter #(.ACCESS_CYCLES(2), .BASE_ADDR(32'd1024), .DEPTH_BYTES(64))
    u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  dmem_arbiter #(.ACCESS_CYCLES(4), .BASE_ADDR(32'd1024), .DEPTH_BYTES(64))
    u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  dmem_arbiter #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024), .DEPTH_BYTES(64))
    u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  logic [31:0] mem2 [16];
  logic [31:0] mem4 [16];
  logic [31:0] mem1 [16];
  int rd2 = 0, wr2 = 0, rd4 = 0, wr4 = 0, rd1 = 0, wr1 = 0;

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 0)  return 32'hDEADBEEF;
    if (i == 1)  return 32'hA5A50001;
    if (i == 15) return 32'hCAFE000F;
    return 32'h5A5A0000 | 32'(i);
  endfunction

  function automatic logic in_mem(input logic [31:0] a);
    return (a >= 32'd1024) && (a < 32'd1088);
  endfunction

  assign b2.mem_rdata = in_mem(b2.mem_addr) ? mem2[b2.mem_addr[5:2]] : '0;
  assign b4.mem_rdata = in_mem(b4.mem_addr) ? mem4[b4.mem_addr[5:2]] : '0;
  assign b1.mem_rdata = in_mem(b1.mem_addr) ? mem1[b1.mem_addr[5:2]] : '0;

  // Memories: strobes sampled mid-cycle, write committed on the closing edge.
  initial begin : m2
    logic [3:0] a;
    logic [31:0] d;
    for (int unsigned i = 0; i < 16; i++) mem2[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (b2.mem_read) rd2++;
      if (b2.mem_write) begin
        wr2++; a = b2.mem_addr[5:2]; d = b2.mem_wdata;
        @(posedge clk);
        if (!rst) mem2[a] = d;
      end
    end
  end

  initial begin : m4
    logic [3:0] a;
    logic [31:0] d;
    for (int unsigned i = 0; i < 16; i++) mem4[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (b4.mem_read) rd4++;
      if (b4.mem_write) begin
        wr4++; a = b4.mem_addr[5:2]; d = b4.mem_wdata;
        @(posedge clk);
        if (!rst) mem4[a] = d;
      end
    end
  end

  initial begin : m1
    logic [3:0] a;
    logic [31:0] d;
    for (int unsigned i = 0; i < 16; i++) mem1[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (b1.mem_read) rd1++;
      if (b1.mem_write) begin
        wr1++; a = b1.mem_addr[5:2]; d = b1.mem_wdata;
        @(posedge clk);
        if (!rst) mem1[a] = d;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic drive_idle;
    b2.req0 = 0; b2.req1 = 0; b2.we0 = 0; b2.we1 = 0;
    b2.addr0 = '0; b2.addr1 = '0; b2.wdata0 = '0; b2.wdata1 = '0;
    b4.req0 = 0; b4.req1 = 0; b4.we0 = 0; b4.we1 = 0;
    b4.addr0 = '0; b4.addr1 = '0; b4.wdata0 = '0; b4.wdata1 = '0;
    b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
    b1.addr0 = '0; b1.addr1 = '0; b1.wdata0 = '0; b1.wdata1 = '0;
  endtask

  task automatic test_reset;
    logic [135:0] o2, o4, o1;
    drive_idle();
    tick();
    o2 = {b2.ack0, b2.ack1, b2.err0, b2.err1, b2.freeze, b2.mem_read, b2.mem_write,
          b2.busy, b2.mem_addr, b2.mem_wdata, b2.rdata0, b2.rdata1};
    o4 = {b4.ack0, b4.ack1, b4.err0, b4.err1, b4.freeze, b4.mem_read, b4.mem_write,
          b4.busy, b4.mem_addr, b4.mem_wdata, b4.rdata0, b4.rdata1};
    o1 = {b1.ack0, b1.ack1, b1.err0, b1.err1, b1.freeze, b1.mem_read, b1.mem_write,
          b1.busy, b1.mem_addr, b1.mem_wdata, b1.rdata0, b1.rdata1};
    n_vec++; if (o2 !== '0) begin n_err++; $display("FAIL reset_outs_ac2: got %h want 0", o2); end
    n_vec++; if (o4 !== '0) begin n_err++; $display("FAIL reset_outs_ac4: got %h want 0", o4); end
    n_vec++; if (o1 !== '0) begin n_err++; $display("FAIL reset_outs_ac1: got %h want 0", o1); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read;
    int rd0;
    rd0 = rd2;
    b2.req0 = 1; b2.we0 = 0; b2.addr0 = 32'd1026;
    #1;
    n_vec++; if (b2.freeze !== 1'b1) begin n_err++; $display("FAIL rd_freeze_req: got %b want 1", b2.freeze); end
    tick();
    n_vec++; if (b2.mem_read !== 1'b1) begin n_err++; $display("FAIL rd_strobe1: got %b want 1", b2.mem_read); end
    n_vec++; if (b2.mem_addr !== 32'd1024) begin n_err++; $display("FAIL rd_addr: got %0d want 1024", b2.mem_addr); end
    n_vec++; if (b2.ack0 !== 1'b0) begin n_err++; $display("FAIL rd_early_ack1: got %b want 0", b2.ack0); end
    tick();
    n_vec++; if (b2.mem_read !== 1'b1) begin n_err++; $display("FAIL rd_strobe2: got %b want 1", b2.mem_read); end
    n_vec++; if (b2.ack0 !== 1'b0) begin n_err++; $display("FAIL rd_early_ack2: got %b want 0", b2.ack0); end
    n_vec++; if (b2.freeze !== 1'b1) begin n_err++; $display("FAIL rd_freeze_hold: got %b want 1", b2.freeze); end
    tick();
    n_vec++; if (b2.ack0 !== 1'b1) begin n_err++; $display("FAIL rd_ack0: got %b want 1", b2.ack0); end
    n_vec++; if (b2.freeze !== 1'b0) begin n_err++; $display("FAIL rd_freeze_ack: got %b want 0", b2.freeze); end
    n_vec++; if (b2.rdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata0: got %h want deadbeef", b2.rdata0); end
    n_vec++; if (b2.mem_read !== 1'b0) begin n_err++; $display("FAIL rd_strobe_done: got %b want 0", b2.mem_read); end
    n_vec++; if (rd2 - rd0 !== 2) begin n_err++; $display("FAIL rd_strobe_cycles: got %0d want 2", rd2 - rd0); end
    b2.req0 = 0;
    tick();
    n_vec++; if (b2.busy !== 1'b0) begin n_err++; $display("FAIL rd_idle_busy: got %b want 0", b2.busy); end
    n_vec++; if (b2.rdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata_hold: got %h want deadbeef", b2.rdata0); end
  endtask

  task automatic test_write_then_read;
    int w0;
    w0 = wr2;
    b2.req1 = 1; b2.we1 = 1; b2.addr1 = 32'd1032; b2.wdata1 = 32'h12345678;
    tick();
    n_vec++; if (b2.mem_write !== 1'b0) begin n_err++; $display("FAIL wr_strobe_early: got %b want 0", b2.mem_write); end
    n_vec++; if (b2.mem_addr !== 32'd1032) begin n_err++; $display("FAIL wr_addr: got %0d want 1032", b2.mem_addr); end
    tick();
    n_vec++; if (b2.mem_write !== 1'b1) begin n_err++; $display("FAIL wr_strobe_last: got %b want 1", b2.mem_write); end
    n_vec++; if (b2.mem_wdata !== 32'h12345678) begin n_err++; $display("FAIL wr_wdata: got %h want 12345678", b2.mem_wdata); end
    tick();
    n_vec++; if ({b2.ack1, b2.ack0, b2.err1} !== 3'b100) begin n_err++; $display("FAIL wr_ack1: got %b want 100", {b2.ack1, b2.ack0, b2.err1}); end
    b2.req1 = 0; b2.we1 = 0;
    b2.req0 = 1; b2.we0 = 0; b2.addr0 = 32'd1032;
    tick();
    n_vec++; if (b2.busy !== 1'b0) begin n_err++; $display("FAIL wr_gap_busy: got %b want 0", b2.busy); end
    tick();
    tick();
    tick();
    n_vec++; if ({b2.ack0, b2.ack1} !== 2'b10) begin n_err++; $display("FAIL wr_rd_ack0: got %b want 10", {b2.ack0, b2.ack1}); end
    n_vec++; if (b2.rdata0 !== 32'h12345678) begin n_err++; $display("FAIL wr_rd_rdata0: got %h want 12345678", b2.rdata0); end
    n_vec++; if (wr2 - w0 !== 1) begin n_err++; $display("FAIL wr_strobe_count: got %0d want 1", wr2 - w0); end
    n_vec++; if (mem2[2] !== 32'h12345678) begin n_err++; $display("FAIL wr_mem_word: got %h want 12345678", mem2[2]); end
    b2.req0 = 0;
    tick();
  endtask

  task automatic test_round_robin;
    int unsigned exp_port;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    b2.req0 = 1; b2.we0 = 0; b2.addr0 = 32'd1024;
    b2.req1 = 1; b2.we1 = 0; b2.addr1 = 32'd1028;
    for (int unsigned k = 0; k < 4; k++) begin
      exp_port = k % 2;
      tick(); tick(); tick();
      n_vec++;
      if ({b2.ack0, b2.ack1} !== ((exp_port == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rr_grant%0d: got ack0ack1=%b want port %0d", k, {b2.ack0, b2.ack1}, exp_port);
      end
      n_vec++;
      if ((exp_port == 0) ? (b2.rdata0 !== 32'hDEADBEEF) : (b2.rdata1 !== 32'hA5A50001)) begin
        n_err++; $display("FAIL rr_rdata%0d: got %h/%h want port %0d data", k, b2.rdata0, b2.rdata1, exp_port);
      end
      tick();
    end
    b2.req0 = 0; b2.req1 = 0;
    tick();
  endtask

  task automatic test_out_of_range;
    int rd0, w0;
    rd0 = rd2; w0 = wr2;
    b2.req0 = 1; b2.we0 = 0; b2.addr0 = 32'd1088;
    tick();
    n_vec++; if ({b2.ack0, b2.err0} !== 2'b11) begin n_err++; $display("FAIL oor_ack_err0: got %b want 11", {b2.ack0, b2.err0}); end
    n_vec++; if (b2.rdata0 !== 32'h0) begin n_err++; $display("FAIL oor_rdata0: got %h want 0", b2.rdata0); end
    b2.req0 = 0;
    tick();
    b2.req1 = 1; b2.we1 = 1; b2.addr1 = 32'd1020; b2.wdata1 = 32'hFFFFFFFF;
    tick();
    n_vec++; if ({b2.ack1, b2.err1, b2.mem_write} !== 3'b110) begin n_err++; $display("FAIL oor_ack_err1: got %b want 110", {b2.ack1, b2.err1, b2.mem_write}); end
    b2.req1 = 0; b2.we1 = 0;
    tick();
    n_vec++; if ({rd2 - rd0, wr2 - w0} !== {32'd0, 32'd0}) begin n_err++; $display("FAIL oor_no_strobe: got rd %0d wr %0d want 0 0", rd2 - rd0, wr2 - w0); end
    n_vec++; if (mem2[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL oor_mem_unchanged: got %h want deadbeef", mem2[0]); end
    b2.req0 = 1; b2.we0 = 0; b2.addr0 = 32'd1087;
    tick(); tick(); tick();
    n_vec++; if ({b2.ack0, b2.err0} !== 2'b10) begin n_err++; $display("FAIL edge_ack0: got %b want 10", {b2.ack0, b2.err0}); end
    n_vec++; if (b2.rdata0 !== 32'hCAFE000F) begin n_err++; $display("FAIL edge_rdata0: got %h want cafe000f", b2.rdata0); end
    b2.req0 = 0;
    tick();
  endtask

  task automatic test_reset_abort;
    int w0;
    logic [135:0] o4;
    w0 = wr4;
    b4.req1 = 1; b4.we1 = 1; b4.addr1 = 32'd1032; b4.wdata1 = 32'h0BADF00D;
    tick();
    tick();
    n_vec++; if (b4.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b want 1", b4.busy); end
    #2 rst = 1'b1;
    #1;
    o4 = {b4.ack0, b4.ack1, b4.err0, b4.err1, b4.freeze, b4.mem_read, b4.mem_write,
          b4.busy, b4.mem_addr, b4.mem_wdata, b4.rdata0, b4.rdata1};
    n_vec++; if (o4 !== '0) begin n_err++; $display("FAIL abort_outs: got %h want 0", o4); end
    tick();
    n_vec++; if ({b4.ack1, b4.busy} !== 2'b00) begin n_err++; $display("FAIL abort_hold1: got %b want 00", {b4.ack1, b4.busy}); end
    tick();
    n_vec++; if ({b4.ack1, b4.busy} !== 2'b00) begin n_err++; $display("FAIL abort_hold2: got %b want 00", {b4.ack1, b4.busy}); end
    b4.req1 = 0; b4.we1 = 0;
    #1 rst = 1'b0;
    tick();
    n_vec++; if (wr4 - w0 !== 0) begin n_err++; $display("FAIL abort_no_write: got %0d want 0", wr4 - w0); end
    n_vec++; if (mem4[2] !== 32'h5A5A0002) begin n_err++; $display("FAIL abort_mem: got %h want 5a5a0002", mem4[2]); end
    b4.req0 = 1; b4.we0 = 0; b4.addr0 = 32'd1024;
    tick(); tick(); tick(); tick();
    n_vec++; if ({b4.ack0, b4.mem_read} !== 2'b01) begin n_err++; $display("FAIL ac4_last_access: got %b want 01", {b4.ack0, b4.mem_read}); end
    tick();
    n_vec++; if (b4.ack0 !== 1'b1) begin n_err++; $display("FAIL ac4_ack0: got %b want 1", b4.ack0); end
    n_vec++; if (b4.rdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL ac4_rdata0: got %h want deadbeef", b4.rdata0); end
    b4.req0 = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 32'd1024;
    tick();
    n_vec++; if ({b1.busy, b1.mem_read, b1.ack0} !== 3'b110) begin n_err++; $display("FAIL b2b_access1: got %b want 110", {b1.busy, b1.mem_read, b1.ack0}); end
    tick();
    n_vec++; if (b1.ack0 !== 1'b1) begin n_err++; $display("FAIL b2b_ack_first: got %b want 1", b1.ack0); end
    n_vec++; if (b1.rdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_rdata_first: got %h want deadbeef", b1.rdata0); end
    b1.addr0 = 32'd1028;
    tick();
    n_vec++; if ({b1.busy, b1.ack0} !== 2'b00) begin n_err++; $display("FAIL b2b_gap: got %b want 00", {b1.busy, b1.ack0}); end
    tick();
    n_vec++; if ({b1.busy, b1.ack0} !== 2'b10) begin n_err++; $display("FAIL b2b_access2: got %b want 10", {b1.busy, b1.ack0}); end
    tick();
    n_vec++; if (b1.ack0 !== 1'b1) begin n_err++; $display("FAIL b2b_ack_second: got %b want 1", b1.ack0); end
    n_vec++; if (b1.rdata0 !== 32'hA5A50001) begin n_err++; $display("FAIL b2b_rdata_second: got %h want a5a50001", b1.rdata0); end
    b1.req0 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_then_read();
    test_round_robin();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
